// File: rtl/wait_state_mem_if.sv
// Memory handshake bundle between the MAR/MDR initiator and the wait-state memory.
interface wait_state_mem_if;
    logic        EN;
    logic        RW;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        MFC;
    logic        err;

    modport master (
        output EN, RW, addr, data_in,
        input  data_out, MFC, err
    );

    modport slave (
        input  EN, RW, addr, data_in,
        output data_out, MFC, err
    );
endinterface

// File: rtl/wait_state_mem.sv
// Word-addressed 16-bit memory responding on the EN/RW/MFC four-phase
// handshake, with a programmable number of wait states and an
// out-of-range flag. DEPTH must be at least 2 and at most 65536.
module wait_state_mem #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,     // asynchronous, active low
    wait_state_mem_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        mfc_q, mfc_d;
    logic        err_q, err_d;
    logic [15:0] dout_q;
    logic        complete;

    logic [15:0] mem [DEPTH];

    // Full 16-bit compare: out-of-range addresses never alias into the array.
    logic          in_range;
    logic [AW-1:0] idx;
    assign in_range = ({16'h0000, addr_q} < DEPTH_U);
    assign idx      = addr_q[AW-1:0];

    // Handshake sequencing: capture, count wait states, complete, wait for EN low.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mfc_d    = mfc_q;
        err_d    = err_q;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.EN) begin
                    rw_d    = bus.RW;
                    addr_d  = bus.addr;
                    wdata_d = bus.data_in;
                    cnt_d   = WAIT_CNT;
                    err_d   = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!bus.EN) begin
                    state_d = IDLE;               // abort: nothing is committed
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    mfc_d    = 1'b1;
                    err_d    = ~in_range;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!bus.EN) begin
                    mfc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and captured-request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
        end
    end

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (complete && !rw_q && in_range) begin
            mem[idx] <= wdata_q;
        end
    end

    // Registered read data, updated only by a completed read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= 16'h0000;
        end else if (complete && rw_q) begin
            dout_q <= in_range ? mem[idx] : 16'h0000;
        end
    end

    assign bus.data_out = dout_q;
    assign bus.MFC      = mfc_q;
    assign bus.err      = err_q;
endmodule
